piso: RTL and testbench
=======================

PISO -- requirements
Module: piso

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width in bits; legal range WIDTH >= 2.
REQ-002 Parameter MSB_FIRST, default 1: 1 = serialize bit WIDTH-1 first; 0 = serialize bit 0 first.
REQ-003 The design SHALL use one clock, clk, and one reset, reset; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 par_in  input  WIDTH  parallel word to serialize; sampled only on accept.
REQ-007 load_valid  input  1  par_in holds a word offered for loading.
REQ-008 load_ready  output  1  block can accept a word this cycle.
REQ-009 serial_out  output  1  current serial bit.
REQ-010 serial_valid  output  1  serial_out carries a data bit this cycle.
REQ-011 last  output  1  serial_out is the final bit of the current word.
REQ-012 busy  output  1  a word is being shifted out.

Function
REQ-013 Accept SHALL occur on a rising edge where load_valid and load_ready are both 1; par_in SHALL be captured into the shift register, the bit counter SHALL clear to 0, and the state SHALL become SHIFT.
REQ-014 The FSM SHALL have two states: IDLE and SHIFT; IDLE->SHIFT on accept; SHIFT->SHIFT on each bit while counter < WIDTH-1, or on an accept during the last bit; SHIFT->IDLE after the last bit with no accept.
REQ-015 load_ready SHALL be 1 in IDLE and in SHIFT while last=1; it SHALL be 0 otherwise.
REQ-016 load_valid without load_ready SHALL be ignored; par_in changes SHALL NOT affect a word in flight.
REQ-017 Latency: the first bit SHALL appear on serial_out in the cycle immediately after the accept edge; one word SHALL occupy exactly WIDTH consecutive serial_valid cycles.
REQ-018 Bit order: with MSB_FIRST=1, bits SHALL be sent in the order par_in[WIDTH-1] down to par_in[0]; with MSB_FIRST=0, in the order par_in[0] up to par_in[WIDTH-1].
REQ-019 serial_valid and busy SHALL be 1 exactly in SHIFT; last SHALL be 1 exactly when in SHIFT with counter = WIDTH-1.
REQ-020 serial_out SHALL be 0 whenever serial_valid=0, and SHALL be driven from a flop output with no combinational path from the inputs.
REQ-021 An accept during the last bit SHALL start the next word in the following cycle, giving a gapless stream with no idle cycle between words.
REQ-022 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap past WIDTH-1.

Reset
REQ-023 While reset=1 at a rising edge, the block SHALL enter IDLE, clear the counter and shift register, and drive serial_out=0, serial_valid=0, last=0, busy=0 and load_ready=1 in the next cycle.
REQ-024 A reset during a word SHALL abort that word with no further bits; reset SHALL take priority over a simultaneous accept.

Structure
REQ-025 The state encodings IDLE and SHIFT SHALL live in the shared package piso_pkg; WIDTH and MSB_FIRST SHALL remain module parameters.
REQ-026 The design SHALL be a single module with no sub-modules.

Verification (WIDTH=4 unless stated)
REQ-027 Reset held for 2 cycles -> serial_out=0, serial_valid=0, last=0, busy=0, load_ready=1.
REQ-028 Single load of 4'b1011 with MSB_FIRST=1 -> serial_out = 1,0,1,1 on the 4 cycles after accept, last=1 on the 4th cycle only, then serial_valid=0.
REQ-029 load_valid held with 4'b1011 then 4'b0110 -> 8 contiguous valid bits 1,0,1,1,0,1,1,0, load_ready=1 only on the 4th bit cycle, no gap.
REQ-030 load_valid pulsed with 4'b0000 during bit 2 of 4'b1111 -> ignored; output is 1,1,1,1, then serial_valid=0.
REQ-031 Reset asserted during bit 2 of 4'b1011 -> next cycle serial_valid=0 and load_ready=1; a subsequent load of 4'b1100 yields 1,1,0,0.
REQ-032 MSB_FIRST=0 with a load of 4'b1011 -> serial_out = 1,1,0,1.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out shifter.
// Holds the FSM state encoding used by piso.
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/piso.sv
// Parallel-in serial-out shifter with valid/ready load handshake.
// Back-to-back words stream gaplessly when loaded during the last bit.
module piso
   import piso_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] par_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             last,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_nxt;
   logic             bit_nxt;
   logic             first_bit;
   logic             accept;

   assign serial_valid = (state == SHIFT);
   assign busy         = (state == SHIFT);
   assign last         = (state == SHIFT) && (cnt == LAST_CNT);
   assign load_ready   = (state == IDLE) || last;
   assign accept       = load_valid && load_ready;

   // The shift register always holds the bit currently on serial_out at
   // its outgoing end, so the next bit is the neighbour of that end.
   always_comb begin
      shreg_nxt = '0;
      bit_nxt   = 1'b0;
      first_bit = 1'b0;
      if (MSB_FIRST != 0) begin
         shreg_nxt = shreg << 1;
         bit_nxt   = shreg[WIDTH-2];
         first_bit = par_in[WIDTH-1];
      end else begin
         shreg_nxt = shreg >> 1;
         bit_nxt   = shreg[1];
         first_bit = par_in[0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         shreg      <= '0;
         serial_out <= 1'b0;
      end else if (accept) begin
         state      <= SHIFT;
         cnt        <= '0;
         shreg      <= par_in;
         serial_out <= first_bit;
      end else if (state == SHIFT) begin
         if (cnt == LAST_CNT) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            serial_out <= 1'b0;
         end else begin
            cnt        <= CW'(cnt + 1'b1);
            shreg      <= shreg_nxt;
            serial_out <= bit_nxt;
         end
      end
   end

endmodule

// File: tb/tb_piso.sv
// Directed scoreboard bench for piso: side 0 is MSB-first, side 1 LSB-first.
// Both instances see identical stimulus; each has its own expected queue.
module tb_piso;

   typedef struct packed {
      logic b;
      logic l;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [3:0] par_in;
   logic       load_valid;
   logic       rdy [2];
   logic       so  [2];
   logic       sv  [2];
   logic       lst [2];
   logic       bsy [2];

   exp_t q [2][$];
   int total;
   int bad;

   piso #(.WIDTH(4), .MSB_FIRST(1)) dut_msb (
      .clk(clk), .reset(reset), .par_in(par_in),
      .load_valid(load_valid), .load_ready(rdy[0]),
      .serial_out(so[0]), .serial_valid(sv[0]),
      .last(lst[0]), .busy(bsy[0])
   );

   piso #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (
      .clk(clk), .reset(reset), .par_in(par_in),
      .load_valid(load_valid), .load_ready(rdy[1]),
      .serial_out(so[1]), .serial_valid(sv[1]),
      .last(lst[1]), .busy(bsy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int s,
                      input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s side=%0d observed=%0h expected=%0h",
                tag, s, obs, exp);
      end
   endtask

   // Expected bits go in transmit order; LSB-first side reverses the word.
   task automatic push_word(input logic [3:0] w);
      logic [3:0] tmp;
      tmp = w;
      for (int i = 0; i < 4; i++) begin
         q[0].push_back('{b: tmp[3-i], l: (i == 3)});
         q[1].push_back('{b: tmp[i],   l: (i == 3)});
      end
   endtask

   task automatic check_side(input int s);
      exp_t e;
      if (sv[s]) begin
         chk("busy_on", s, 8'(bsy[s]), 8'd1);
         if (q[s].size() == 0) begin
            chk("extra_bit", s, 8'd1, 8'd0);
         end else begin
            e = q[s].pop_front();
            chk("bit", s, 8'(so[s]), 8'(e.b));
            chk("last", s, 8'(lst[s]), 8'(e.l));
            chk("ready_shift", s, 8'(rdy[s]), 8'(e.l));
         end
      end else begin
         chk("so_zero", s, 8'(so[s]), 8'd0);
         chk("last_idle", s, 8'(lst[s]), 8'd0);
         chk("busy_idle", s, 8'(bsy[s]), 8'd0);
         chk("ready_idle", s, 8'(rdy[s]), 8'd1);
         chk("gap", s, 8'(q[s].size()), 8'd0);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      check_side(0);
      check_side(1);
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      reset      = 1'b1;
      load_valid = 1'b0;
      par_in     = 4'h0;

      // reset held two cycles
      step();
      step();
      chk("rst_valid", 0, 8'(sv[0]), 8'd0);
      chk("rst_ready", 0, 8'(rdy[0]), 8'd1);
      reset = 1'b0;
      step();

      // single word 1011
      load_valid = 1'b1;
      par_in     = 4'b1011;
      push_word(4'b1011);
      step();
      load_valid = 1'b0;
      par_in     = 4'b0000;
      repeat (3) step();
      step();
      chk("single_done", 0, 8'(sv[0]), 8'd0);

      // load_valid held: 1011 then 0110, gapless
      load_valid = 1'b1;
      par_in     = 4'b1011;
      push_word(4'b1011);
      repeat (4) step();
      chk("b2b_ready_last", 0, 8'(rdy[0]), 8'd1);
      par_in = 4'b0110;
      push_word(4'b0110);
      step();
      chk("b2b_no_gap", 0, 8'(sv[0]), 8'd1);
      load_valid = 1'b0;
      repeat (3) step();
      step();
      chk("b2b_done", 1, 8'(sv[1]), 8'd0);

      // ignored pulse of 0000 during bit 2 of 1111
      load_valid = 1'b1;
      par_in     = 4'b1111;
      push_word(4'b1111);
      step();
      load_valid = 1'b0;
      step();
      load_valid = 1'b1;
      par_in     = 4'b0000;
      step();
      load_valid = 1'b0;
      step();
      step();
      chk("ignore_done", 0, 8'(sv[0]), 8'd0);

      // reset during bit 2 of 1011, then load 1100
      load_valid = 1'b1;
      par_in     = 4'b1011;
      push_word(4'b1011);
      step();
      load_valid = 1'b0;
      step();
      reset = 1'b1;
      q[0].delete();
      q[1].delete();
      step();
      chk("abort_valid", 0, 8'(sv[0]), 8'd0);
      chk("abort_ready", 1, 8'(rdy[1]), 8'd1);
      reset      = 1'b0;
      load_valid = 1'b1;
      par_in     = 4'b1100;
      push_word(4'b1100);
      step();
      load_valid = 1'b0;
      repeat (3) step();
      step();

      // reset wins over a simultaneous accept
      reset      = 1'b1;
      load_valid = 1'b1;
      par_in     = 4'b1010;
      step();
      chk("rst_prio", 0, 8'(sv[0]), 8'd0);
      chk("rst_prio", 1, 8'(sv[1]), 8'd0);
      reset      = 1'b0;
      load_valid = 1'b0;
      step();

      chk("q_empty", 0, 8'(q[0].size()), 8'd0);
      chk("q_empty", 1, 8'(q[1].size()), 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
